serial_addsub_unit: RTL and testbench



---
 rtl/serial_addsub_unit.sv | 151 +++++++++++++++
 tb/tb_serial_addsub_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_unit.sv
// ---------------------------------------------------------------------------
// serial_addsub_unit
//
// Digit-serial 32-bit adder/subtractor. One operation takes 32/DIGIT_W digit
// cycles behind a start/done handshake. Subtraction is done as A + ~B + 1, so
// the same narrow DIGIT_W-bit carry chain serves both operations. Results and
// flags are registered and held until the next completion, which lets the
// downstream set-condition stage read them at leisure.
//
// Ports:
//   clk     in   1   clock, rising edge
//   rst     in   1   asynchronous active-high reset
//   start   in   1   operation request, sampled only while idle
//   sub     in   1   1 = a - b, 0 = a + b (sampled with start)
//   a, b    in   32  operands (sampled with start)
//   busy    out  1   operation in progress
//   done    out  1   one-cycle pulse when results are updated
//   result  out  32  registered sum/difference
//   zf, nz  out  1   result == 0 / result != 0
//   cout    out  1   carry out of bit 31 (for subtract, 1 = no borrow)
//   ovf     out  1   signed two's-complement overflow
// ---------------------------------------------------------------------------
module serial_addsub_unit #(
    parameter int DIGIT_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sub,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        zf,
    output logic        nz,
    output logic        cout,
    output logic        ovf
);

    localparam int N     = 32 / DIGIT_W;
    localparam int CNT_W = $clog2(N) + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      a_sh;
    logic [31:0]      b_sh;
    logic [31:0]      r_sh;
    logic             c;
    logic             sa;
    logic             sb;

    logic [31:0]      b_in;
    logic [DIGIT_W:0] digit_sum;
    logic [DIGIT_W-1:0] s;
    logic             c_n;
    logic [31:0]      r_next;
    logic             last_digit;

    // Operand B is inverted up front for subtraction; the +1 comes in through
    // the initial carry, so the digit loop never needs to know which op it is.
    assign b_in = b ^ {32{sub}};

    // One digit of the ripple add: the only carry chain in the design.
    assign digit_sum = {1'b0, a_sh[DIGIT_W-1:0]}
                     + {1'b0, b_sh[DIGIT_W-1:0]}
                     + {{DIGIT_W{1'b0}}, c};
    assign s   = digit_sum[DIGIT_W-1:0];
    assign c_n = digit_sum[DIGIT_W];

    // The new digit enters at the top while older digits move down, so after
    // N digits the least significant digit has arrived at bit 0. Written as
    // shifts so that DIGIT_W = 32 needs no special slice.
    assign r_next = (r_sh >> DIGIT_W) | (32'(s) << (32 - DIGIT_W));

    assign last_digit = (cnt == CNT_W'(N - 1));

    // busy comes straight from the state register, so it is glitch-free and
    // has no path from the inputs.
    assign busy = (state == RUN);

    // Control and datapath shift registers. A start in IDLE loads the operands
    // and the sign bits needed for overflow; RUN consumes one digit per edge
    // and returns to IDLE after the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            c     <= 1'b0;
            sa    <= 1'b0;
            sb    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b_in;
                        c     <= sub;
                        cnt   <= '0;
                        sa    <= a[31];
                        sb    <= b_in[31];
                        state <= RUN;
                    end
                end
                RUN: begin
                    r_sh <= r_next;
                    a_sh <= a_sh >> DIGIT_W;
                    b_sh <= b_sh >> DIGIT_W;
                    c    <= c_n;
                    cnt  <= cnt + 1'b1;
                    if (last_digit) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output registers only move on the completion edge, so the previous
    // result stays visible to the consumer for the whole next operation.
    // Overflow uses the effective B sign: same-sign inputs whose result
    // changed sign.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done   <= 1'b0;
            result <= '0;
            zf     <= 1'b0;
            nz     <= 1'b0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == RUN && last_digit) begin
                done   <= 1'b1;
                result <= r_next;
                cout   <= c_n;
                zf     <= (r_next == 32'd0);
                nz     <= (r_next != 32'd0);
                ovf    <= (sa == sb) && (r_next[31] != sa);
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub_unit
//
// Scoreboard bench for serial_addsub_unit (DIGIT_W = 4). Each accepted
// request pushes the expected result, computed with plain 64-bit signed and
// unsigned arithmetic, onto a queue. A monitor pops an entry whenever done
// pulses, and between completions it checks that the held outputs have not
// moved.
// ---------------------------------------------------------------------------
module tb_serial_addsub_unit;

    localparam int DIGIT_W = 4;
    localparam int N       = 32 / DIGIT_W;

    typedef struct {
        logic [31:0] res;
        logic        zf;
        logic        nz;
        logic        cout;
        logic        ovf;
        int          done_edge;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zf;
    logic        nz;
    logic        cout;
    logic        ovf;

    exp_t sb_q[$];
    exp_t held;
    int   edge_cnt;
    int   checks;
    int   failures;
    logic mon_en;

    serial_addsub_unit #(.DIGIT_W(DIGIT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zf     (zf),
        .nz     (nz),
        .cout   (cout),
        .ovf    (ovf)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rising-edge counter, used to check completion latency
    always @(posedge clk) begin
        edge_cnt++;
    end

    // Reference: exact integer arithmetic, then wrap and derive flags
    function automatic exp_t ref_model(input logic [31:0] op_a, input logic [31:0] op_b,
                                       input logic op_sub);
        exp_t   e;
        longint ua;
        longint ub;
        longint sa;
        longint sb;
        longint exact_u;
        longint exact_s;
        ua = longint'({32'd0, op_a});
        ub = longint'({32'd0, op_b});
        sa = longint'($signed(op_a));
        sb = longint'($signed(op_b));
        exact_u = op_sub ? ua - ub : ua + ub;
        exact_s = op_sub ? sa - sb : sa + sb;
        e.res  = exact_u[31:0];
        e.cout = op_sub ? (ua >= ub) : (exact_u > 64'sd4294967295);
        e.ovf  = (exact_s > 64'sd2147483647) || (exact_s < -64'sd2147483648);
        e.zf   = (e.res == 32'd0);
        e.nz   = !e.zf;
        e.done_edge = 0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Wait for idle, present one request, push its expected response
    task automatic applyStimulus(input logic [31:0] op_a, input logic [31:0] op_b,
                                 input logic op_sub);
        exp_t e;
        int   bound;
        @(negedge clk);
        bound = 0;
        while (busy && bound < 100) begin
            @(negedge clk);
            bound++;
        end
        if (bound >= 100) begin
            checkOutput("idle_timeout", 64'(busy), 64'd0);
        end
        start = 1'b1;
        a     = op_a;
        b     = op_b;
        sub   = op_sub;
        @(posedge clk);
        #1;
        start = 1'b0;
        e = ref_model(op_a, op_b, op_sub);
        e.done_edge = edge_cnt + N;
        sb_q.push_back(e);
        checkOutput("busy_after_start", 64'(busy), 64'd1);
    endtask

    // Requests made while busy must be dropped without effect
    task automatic applyIgnored(input int count);
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            start = 1'b1;
            a     = $urandom;
            b     = $urandom;
            sub   = 1'($urandom);
            checkOutput("busy_during_ignored", 64'(busy), 64'd1);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    // Monitor: pop on done, otherwise outputs must hold the last completion
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !rst) begin
            if (done) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("result", 64'(result), 64'(e.res));
                    checkOutput("flags_zf_nz_cout_ovf", 64'({zf, nz, cout, ovf}),
                                64'({e.zf, e.nz, e.cout, e.ovf}));
                    checkOutput("done_latency", 64'(edge_cnt), 64'(e.done_edge));
                    checkOutput("busy_at_done", 64'(busy), 64'd0);
                    held = e;
                end
            end else begin
                checkOutput("hold", 64'({result, zf, nz, cout, ovf}),
                            64'({held.res, held.zf, held.nz, held.cout, held.ovf}));
            end
        end
    end

    initial begin
        int bound;
        checks   = 0;
        failures = 0;
        edge_cnt = 0;
        mon_en   = 1'b0;
        held     = '{res: 32'd0, zf: 1'b0, nz: 1'b0, cout: 1'b0, ovf: 1'b0, done_edge: 0};
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_state", 64'({busy, done, result, zf, nz, cout, ovf}), 64'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Directed corner cases
        applyStimulus(32'd5, 32'd3, 1'b1);
        applyStimulus(32'h12345678, 32'h12345678, 1'b1);
        applyStimulus(32'd3, 32'd5, 1'b1);
        applyStimulus(32'h7FFFFFFF, 32'd1, 1'b0);
        applyStimulus(32'hFFFFFFFF, 32'd1, 1'b0);
        applyStimulus(32'h80000000, 32'd1, 1'b1);
        applyStimulus(32'h00000000, 32'h00000000, 1'b0);

        // Extra starts while busy are ignored
        applyStimulus(32'd100, 32'd23, 1'b0);
        applyIgnored(2);

        // Randomized mix, sometimes back-to-back in the done cycle
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            applyStimulus(ra, rb, 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                applyIgnored(1);
            end
            repeat ($urandom_range(0, 1) * $urandom_range(0, N + 2)) @(negedge clk);
        end

        // Mid-operation asynchronous reset aborts without done
        applyStimulus(32'hDEADBEEF, 32'h01234567, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        sb_q.delete();
        held = '{res: 32'd0, zf: 1'b0, nz: 1'b0, cout: 1'b0, ovf: 1'b0, done_edge: 0};
        rst = 1'b1;
        #1;
        checkOutput("async_reset", 64'({busy, done, result, zf, nz, cout, ovf}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (N + 3) @(negedge clk);
        applyStimulus(32'd5, 32'd3, 1'b1);

        // Drain outstanding expectations
        bound = 0;
        while (sb_q.size() != 0 && bound < 200) begin
            @(negedge clk);
            bound++;
        end
        @(negedge clk);
        checkOutput("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
